// File: rtl/servo_pkg.sv
// Shared types, 50 MHz timing defaults and the width clamp helper for the
// servo pulse scheduler.
package servo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    // 50 MHz clock: 20 ms frame, 2.5 ms slot, 1 / 1.5 / 2 ms pulse widths
    localparam int FRAME_CYCLES_50M = 1_000_000;
    localparam int SLOT_CYCLES_50M  = 125_000;
    localparam int MIN_W_50M        = 50_000;
    localparam int MAX_W_50M        = 100_000;
    localparam int DEF_W_50M        = 75_000;

    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/servo_width_regs.sv
// Shadow/active pulse-width register file: clamped host writes land in the
// shadow bank, and the active bank copies the shadow bank only on reload.
module servo_width_regs
    import servo_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int CW    = 20,
    parameter  int MIN_W = MIN_W_50M,
    parameter  int MAX_W = MAX_W_50M,
    parameter  int DEF_W = DEF_W_50M,
    localparam int CHW   = $clog2(NCH)
) (
    input  logic           clk0,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_width,
    input  logic           reload,
    output logic           wr_err,
    output logic [CW-1:0]  active [NCH]
);

    logic [CW-1:0] shadow [NCH];
    logic [CW-1:0] wr_clamped;

    assign wr_clamped = CW'(clamp(32'(wr_width), 32'(MIN_W), 32'(MAX_W)));

    // A write coinciding with reload leaves active with the old shadow value,
    // so the new width takes effect one frame later.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= CW'(DEF_W);
                active[i] <= CW'(DEF_W);
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (int'(wr_ch) >= NCH);
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && (wr_ch == CHW'(i)))
                    shadow[i] <= wr_clamped;
                if (reload)
                    active[i] <= shadow[i];
            end
        end
    end

endmodule

// File: rtl/servo_pulse_sched.sv
// Multi-channel servo pulse scheduler: one frame split into per-channel slots.
// Optional readback of active widths is enabled by SERVO_SCHED_READBACK_EN.
module servo_pulse_sched
    import servo_pkg::*;
#(
    parameter  int NCH          = 4,
    parameter  int CW           = 20,
    parameter  int FRAME_CYCLES = FRAME_CYCLES_50M,
    parameter  int SLOT_CYCLES  = SLOT_CYCLES_50M,
    parameter  int MIN_W        = MIN_W_50M,
    parameter  int MAX_W        = MAX_W_50M,
    parameter  int DEF_W        = DEF_W_50M,
    localparam int CHW          = $clog2(NCH)
) (
    input  logic           clk0,
    input  logic           rst,
    input  logic           enable,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_width,
`ifdef SERVO_SCHED_READBACK_EN
    input  logic [CHW-1:0] rd_ch,
    output logic [CW-1:0]  rd_width,
`endif
    output logic           wr_err,
    output logic [NCH-1:0] pwm_out,
    output logic           frame_start,
    output logic [CHW-1:0] cur_ch
);

    state_t         state, state_d;
    logic [CHW-1:0] ch_d;
    logic [CW-1:0]  slot_cnt, slot_d;
    logic [CW-1:0]  frame_cnt, frame_d;
    logic           frame_go;
    logic [CW-1:0]  cur_w;
    logic [CW-1:0]  active [NCH];

    servo_width_regs #(
        .NCH   (NCH),
        .CW    (CW),
        .MIN_W (MIN_W),
        .MAX_W (MAX_W),
        .DEF_W (DEF_W)
    ) u_regs (
        .clk0     (clk0),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_width (wr_width),
        .reload   (frame_go),
        .wr_err   (wr_err),
        .active   (active)
    );

    always_comb begin
        cur_w = '0;
        for (int i = 0; i < NCH; i++)
            if (cur_ch == CHW'(i))
                cur_w = active[i];
    end

    always_comb begin
        state_d  = state;
        ch_d     = cur_ch;
        slot_d   = slot_cnt;
        frame_d  = frame_cnt;
        frame_go = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            ch_d    = '0;
            slot_d  = '0;
            frame_d = '0;
        end else begin
            slot_d  = slot_cnt + CW'(1);
            frame_d = frame_cnt + CW'(1);
            unique case (state)
                S_IDLE: frame_go = 1'b1;
                S_HIGH: begin
                    if (slot_cnt == cur_w - CW'(1))
                        state_d = S_LOW;
                end
                S_LOW: begin
                    if (slot_cnt == CW'(SLOT_CYCLES - 1)) begin
                        if (cur_ch != CHW'(NCH - 1)) begin
                            ch_d    = cur_ch + CHW'(1);
                            slot_d  = '0;
                            state_d = S_HIGH;
                        end else if (frame_cnt == CW'(FRAME_CYCLES - 1)) begin
                            // slots fill the whole frame: no tail to wait out
                            frame_go = 1'b1;
                        end else begin
                            state_d = S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    slot_d = slot_cnt;
                    if (frame_cnt == CW'(FRAME_CYCLES - 1))
                        frame_go = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (frame_go) begin
                state_d = S_HIGH;
                ch_d    = '0;
                slot_d  = '0;
                frame_d = '0;
            end
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_ch      <= '0;
            slot_cnt    <= '0;
            frame_cnt   <= '0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            cur_ch      <= ch_d;
            slot_cnt    <= slot_d;
            frame_cnt   <= frame_d;
            pwm_out     <= (state_d == S_HIGH) ? (NCH'(1) << ch_d) : '0;
            frame_start <= frame_go;
        end
    end

`ifdef SERVO_SCHED_READBACK_EN
    logic [CW-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (rd_ch == CHW'(i))
                rd_sel = active[i];
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst)
            rd_width <= '0;
        else
            rd_width <= rd_sel;
    end
`endif

endmodule
